// File: rtl/ras_pkg.sv
// Shared fetch-predictor sizing for the return address stack.
package ras_pkg;

    localparam int RAS_ENTRIES      = 8;
    localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
    localparam int RAS_TARGET_WIDTH = 31;

endpackage

// File: rtl/ras.sv
// Circular return address stack: push on predicted call, pop on predicted return.
// Optional occupancy tracking is built when RAS_OCCUPANCY_EN is defined.
module ras
    import ras_pkg::*;
#(
    parameter int N_ENTRIES = RAS_ENTRIES,
    parameter int IDX_W     = RAS_INDEX_WIDTH,
    parameter int TGT_W     = RAS_TARGET_WIDTH
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             link_valid,
    input  logic [TGT_W-1:0] link_target,
    input  logic             ret_valid,
    output logic [TGT_W-1:0] ret_target,
    output logic [IDX_W-1:0] ras_index,
`ifdef RAS_OCCUPANCY_EN
    output logic [IDX_W:0]   ras_count,
    output logic             ret_target_valid,
    input  logic [IDX_W:0]   restore_count,
`endif
    input  logic             restore_valid,
    input  logic [IDX_W-1:0] restore_index
);

    logic [TGT_W-1:0] entry_q [N_ENTRIES];
    logic [TGT_W-1:0] entry_d [N_ENTRIES];
    logic [IDX_W-1:0] tos_ptr_q;
    logic [IDX_W-1:0] tos_ptr_d;
    logic [IDX_W-1:0] push_ptr_s;

    assign push_ptr_s = tos_ptr_q + IDX_W'(1);
    assign ret_target = entry_q[tos_ptr_q];
    assign ras_index  = tos_ptr_q;

    // Next-state for pointer and entries; restore outranks push/pop.
    always_comb begin
        entry_d   = entry_q;
        tos_ptr_d = tos_ptr_q;
        if (restore_valid) begin
            tos_ptr_d = restore_index;
        end else if (link_valid && ret_valid) begin
            entry_d[tos_ptr_q] = link_target;
        end else if (link_valid) begin
            tos_ptr_d           = push_ptr_s;
            entry_d[push_ptr_s] = link_target;
        end else if (ret_valid) begin
            tos_ptr_d = tos_ptr_q - IDX_W'(1);
        end else begin
            tos_ptr_d = tos_ptr_q;
        end
    end

    // Stack state registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tos_ptr_q <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            tos_ptr_q <= tos_ptr_d;
            entry_q   <= entry_d;
        end
    end

`ifdef RAS_OCCUPANCY_EN
    localparam logic [IDX_W:0] COUNT_MAX = (IDX_W+1)'(N_ENTRIES);

    logic [IDX_W:0] ras_count_q;
    logic [IDX_W:0] ras_count_d;

    // Saturating occupancy; a replace on an empty stack leaves one live entry.
    always_comb begin
        ras_count_d = ras_count_q;
        if (restore_valid) begin
            ras_count_d = restore_count;
        end else if (link_valid && ret_valid) begin
            if (ras_count_q == '0) begin
                ras_count_d = (IDX_W+1)'(1);
            end else begin
                ras_count_d = ras_count_q;
            end
        end else if (link_valid) begin
            if (ras_count_q == COUNT_MAX) begin
                ras_count_d = ras_count_q;
            end else begin
                ras_count_d = ras_count_q + (IDX_W+1)'(1);
            end
        end else if (ret_valid) begin
            if (ras_count_q == '0) begin
                ras_count_d = ras_count_q;
            end else begin
                ras_count_d = ras_count_q - (IDX_W+1)'(1);
            end
        end else begin
            ras_count_d = ras_count_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ras_count_q <= '0;
        end else begin
            ras_count_q <= ras_count_d;
        end
    end

    assign ras_count        = ras_count_q;
    assign ret_target_valid = (ras_count_q != '0);
`endif

endmodule

// File: tb/tb_ras.sv
// Directed self-checking bench for ras with a queue-based scoreboard fed by a reference model.
module tb_ras;

    logic        CLK;
    logic        nRST;
    logic        link_valid;
    logic [30:0] link_target;
    logic        ret_valid;
    logic [30:0] ret_target;
    logic [2:0]  ras_index;
    logic        restore_valid;
    logic [2:0]  restore_index;
`ifdef RAS_OCCUPANCY_EN
    logic [3:0]  ras_count;
    logic        ret_target_valid;
    logic [3:0]  restore_count;
`endif

    ras dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .link_valid    (link_valid),
        .link_target   (link_target),
        .ret_valid     (ret_valid),
        .ret_target    (ret_target),
        .ras_index     (ras_index),
`ifdef RAS_OCCUPANCY_EN
        .ras_count       (ras_count),
        .ret_target_valid(ret_target_valid),
        .restore_count   (restore_count),
`endif
        .restore_valid (restore_valid),
        .restore_index (restore_index)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [30:0] tgt;
        logic [2:0]  idx;
    } exp_t;

    exp_t        sb_q[$];
    logic [30:0] m_entry [8];
    logic [2:0]  m_tos;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_tos = 3'd0;
        for (int i = 0; i < 8; i++) m_entry[i] = 31'd0;
    endtask

    // Drive one request cycle, predict the post-edge state, then compare it.
    task automatic step(input logic lv, input logic [30:0] lt, input logic rv,
                        input logic sv, input logic [2:0] si);
        exp_t e;
        link_valid    = lv;
        link_target   = lt;
        ret_valid     = rv;
        restore_valid = sv;
        restore_index = si;
        if (sv) m_tos = si;
        else if (lv && rv) m_entry[m_tos] = lt;
        else if (lv) begin
            m_tos = m_tos + 3'd1;
            m_entry[m_tos] = lt;
        end else if (rv) m_tos = m_tos - 3'd1;
        e.tgt = m_entry[m_tos];
        e.idx = m_tos;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        link_valid    = 1'b0;
        ret_valid     = 1'b0;
        restore_valid = 1'b0;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("sb_target", {1'b0, ret_target}, {1'b0, e.tgt});
            chk("sb_index", {29'd0, ras_index}, {29'd0, e.idx});
        end
    endtask

    function automatic logic [30:0] tval(input int k);
        return 31'(32'h0000_0100 * k + 32'h0000_0055);
    endfunction

    initial begin
        logic [30:0] e5;
        logic [2:0]  cp;
        nRST          = 1'b0;
        link_valid    = 1'b0;
        link_target   = 31'd0;
        ret_valid     = 1'b0;
        restore_valid = 1'b0;
        restore_index = 3'd0;
`ifdef RAS_OCCUPANCY_EN
        restore_count = 4'd0;
`endif
        model_reset();
        #2;
        chk("rst_target", {1'b0, ret_target}, 32'd0);
        chk("rst_index", {29'd0, ras_index}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Three pushes then three pops.
        step(1'b1, 31'h0000_1000, 1'b0, 1'b0, 3'd0);
        chk("push1_idx", {29'd0, ras_index}, 32'd1);
        step(1'b1, 31'h0000_2000, 1'b0, 1'b0, 3'd0);
        chk("push2_idx", {29'd0, ras_index}, 32'd2);
        step(1'b1, 31'h0000_3000, 1'b0, 1'b0, 3'd0);
        chk("push3_idx", {29'd0, ras_index}, 32'd3);
        chk("pop1_val", {1'b0, ret_target}, 32'h0000_3000);
        step(1'b0, 31'd0, 1'b1, 1'b0, 3'd0);
        chk("pop2_val", {1'b0, ret_target}, 32'h0000_2000);
        step(1'b0, 31'd0, 1'b1, 1'b0, 3'd0);
        chk("pop3_val", {1'b0, ret_target}, 32'h0000_1000);
        step(1'b0, 31'd0, 1'b1, 1'b0, 3'd0);
        chk("pops_idx", {29'd0, ras_index}, 32'd0);

        // Overflow by one: T1 is overwritten by T9.
        for (int k = 1; k <= 9; k++) step(1'b1, tval(k), 1'b0, 1'b0, 3'd0);
        chk("wrap_idx", {29'd0, ras_index}, 32'd1);
        chk("wrap_top", {1'b0, ret_target}, {1'b0, tval(9)});
        for (int k = 0; k < 8; k++) begin
            chk("wrap_pop", {1'b0, ret_target}, {1'b0, tval(9 - k)});
            step(1'b0, 31'd0, 1'b1, 1'b0, 3'd0);
        end
        chk("stale_pop", {1'b0, ret_target}, {1'b0, tval(9)});
        step(1'b0, 31'd0, 1'b1, 1'b0, 3'd0);

        // Replace at tos 2: old value visible this cycle, new one next.
        step(1'b1, 31'h0000_0AAA, 1'b0, 1'b0, 3'd0);
        step(1'b1, 31'h0000_0A0A, 1'b0, 1'b0, 3'd0);
        chk("repl_pre_idx", {29'd0, ras_index}, 32'd2);
        link_valid  = 1'b1;
        link_target = 31'h0000_0B0B;
        ret_valid   = 1'b1;
        #1;
        chk("repl_same_cycle", {1'b0, ret_target}, 32'h0000_0A0A);
        step(1'b1, 31'h0000_0B0B, 1'b1, 1'b0, 3'd0);
        chk("repl_next_val", {1'b0, ret_target}, 32'h0000_0B0B);
        chk("repl_next_idx", {29'd0, ras_index}, 32'd2);

        // Checkpoint at 4, disturb, then restore alongside an ignored push.
        step(1'b1, 31'h0000_0C0C, 1'b0, 1'b0, 3'd0);
        step(1'b1, 31'h0000_0D0D, 1'b0, 1'b0, 3'd0);
        cp = ras_index;
        chk("cp_idx", {29'd0, cp}, 32'd4);
        e5 = tval(5);
        step(1'b0, 31'd0, 1'b1, 1'b0, 3'd0);
        step(1'b0, 31'd0, 1'b1, 1'b0, 3'd0);
        step(1'b1, 31'h0000_0E0E, 1'b0, 1'b0, 3'd0);
        step(1'b1, 31'h0000_0F0F, 1'b0, 1'b1, cp);
        chk("restore_idx", {29'd0, ras_index}, 32'd4);
        chk("restore_top", {1'b0, ret_target}, 32'h0000_0D0D);
        step(1'b0, 31'd0, 1'b0, 1'b1, 3'd5);
        chk("entry5_kept", {1'b0, ret_target}, {1'b0, e5});

        // Asynchronous reset mid-push, no clock edge in between.
        step(1'b1, 31'h0000_1111, 1'b0, 1'b0, 3'd0);
        link_valid  = 1'b1;
        link_target = 31'h0000_2222;
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst_target", {1'b0, ret_target}, 32'd0);
        chk("async_rst_index", {29'd0, ras_index}, 32'd0);
        link_valid = 1'b0;
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_index", {29'd0, ras_index}, 32'd0);

`ifdef RAS_OCCUPANCY_EN
        chk("cnt_rst", {28'd0, ras_count}, 32'd0);
        step(1'b0, 31'd0, 1'b1, 1'b0, 3'd0);
        chk("cnt_pop_empty", {28'd0, ras_count}, 32'd0);
        chk("valid_empty", {31'd0, ret_target_valid}, 32'd0);
        for (int k = 0; k < 10; k++) step(1'b1, tval(k + 20), 1'b0, 1'b0, 3'd0);
        chk("cnt_sat", {28'd0, ras_count}, 32'd8);
        chk("valid_full", {31'd0, ret_target_valid}, 32'd1);
        restore_count = 4'd3;
        step(1'b0, 31'd0, 1'b0, 1'b1, 3'd2);
        restore_count = 4'd0;
        chk("cnt_restore", {28'd0, ras_count}, 32'd3);
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
